// File: rtl/drift_responder.sv
// drift_responder: half-rate clock generator whose next half period can be
// lengthened or shortened by one sys clock on request from a drift tracker.
// Each accepted request is answered with a one-cycle drift_res_o pulse.

package common_p;
  // Clock/reset bundle for one clock domain.
  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;
endpackage

package clks_alot_p;
  // Delay lengthens the next half period by one cycle; advance shortens it.
  typedef enum logic {
    DRIFT_DELAY   = 1'b0,
    DRIFT_ADVANCE = 1'b1
  } drift_direction_e;
endpackage

module drift_responder #(
  parameter int HALF_RATE_WIDTH = 16
) (
  input  common_p::clk_dom_s             sys_dom_i,
  input  logic                           enable_i,
  input  logic                           clear_state_i,
  input  logic [HALF_RATE_WIDTH-1:0]     half_period_i,
  input  logic                           drift_req_i,
  input  clks_alot_p::drift_direction_e  drift_direction_i,
  output logic                           drift_res_o,
  output logic                           drift_rejected_o,
  output logic                           clk_o,
  output logic                           rise_o,
  output logic                           fall_o
);

  import clks_alot_p::*;

  localparam int W = HALF_RATE_WIDTH;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PENDING   = 2'd1;
  localparam logic [1:0] ACK       = 2'd2;
  localparam logic [1:0] WAIT_DROP = 2'd3;

  localparam logic [W-1:0] MIN_HALF = W'(2);

  logic clk;
  logic rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  logic [W-1:0]     cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [1:0]       state_q, state_d;
  drift_direction_e dir_q, dir_d;
  logic             rej_q, rej_d;

  logic [W-1:0] eff_half;
  logic [W-1:0] reload;
  logic         boundary;
  logic         too_short;
  logic         apply_delay;
  logic         apply_advance;

  // Half-period selection: clamp, decide adjustment and compute reload value.
  always_comb begin
    eff_half      = (half_period_i < MIN_HALF) ? MIN_HALF : half_period_i;
    boundary      = enable_i && (cnt_q == '0);
    too_short     = (eff_half == MIN_HALF);
    apply_delay   = boundary && (state_q == PENDING) && (dir_q == DRIFT_DELAY);
    apply_advance = boundary && (state_q == PENDING) && (dir_q == DRIFT_ADVANCE) && !too_short;
    // A delay reloads eff_half itself, so 2^W-1 fits without wrapping.
    if (apply_delay)        reload = eff_half;
    else if (apply_advance) reload = eff_half - W'(2);
    else                    reload = eff_half - W'(1);
  end

  // Next-state logic for the counter, generated clock and request FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    state_d = state_q;
    dir_d   = dir_q;
    rej_d   = rej_q;

    if (clear_state_i) begin
      cnt_d   = '0;
      clk_d   = 1'b0;
      state_d = IDLE;
      dir_d   = DRIFT_DELAY;
      rej_d   = 1'b0;
    end else if (enable_i) begin
      if (cnt_q == '0) begin
        clk_d  = ~clk_q;
        rise_d = ~clk_q;
        fall_d = clk_q;
        cnt_d  = reload;
      end else begin
        cnt_d = cnt_q - W'(1);
      end

      case (state_q)
        IDLE: begin
          if (drift_req_i) begin
            dir_d   = drift_direction_i;
            rej_d   = 1'b0;
            state_d = PENDING;
          end
        end
        PENDING: begin
          if (boundary) begin
            rej_d   = (dir_q == DRIFT_ADVANCE) && too_short;
            state_d = ACK;
          end
        end
        ACK:       state_d = WAIT_DROP;
        WAIT_DROP: if (!drift_req_i) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      state_q <= IDLE;
      dir_q   <= DRIFT_DELAY;
      rej_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      rej_q   <= rej_d;
    end
  end

  // ACK is held while disabled, so the completion pulse is gated to one enabled cycle.
  assign drift_res_o      = (state_q == ACK) && enable_i;
  assign drift_rejected_o = (state_q == ACK) && enable_i && rej_q;
  assign clk_o            = clk_q;
  assign rise_o           = rise_q;
  assign fall_o           = fall_q;

endmodule

// File: tb/tb_drift_responder.sv
// Scoreboard bench for drift_responder: expected clock edges (gap since the
// previous edge, polarity, completion/reject flags) are queued as stimulus is
// driven, and compared with edges recorded by a negedge monitor.

module tb_drift_responder;

  import clks_alot_p::*;

  localparam int W = 4;

  typedef struct {
    int   gap;
    logic rise;
    logic lvl;
    logic res;
    logic rej;
  } edge_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  common_p::clk_dom_s sys_dom;
  assign sys_dom.clk   = clk;
  assign sys_dom.rst_n = rst_n;

  logic             enable_i;
  logic             clear_state_i;
  logic [W-1:0]     half_period_i;
  logic             drift_req_i;
  drift_direction_e drift_direction_i;
  logic             drift_res_o;
  logic             drift_rejected_o;
  logic             clk_o;
  logic             rise_o;
  logic             fall_o;

  drift_responder #(.HALF_RATE_WIDTH(W)) dut (
    .sys_dom_i         (sys_dom),
    .enable_i          (enable_i),
    .clear_state_i     (clear_state_i),
    .half_period_i     (half_period_i),
    .drift_req_i       (drift_req_i),
    .drift_direction_i (drift_direction_i),
    .drift_res_o       (drift_res_o),
    .drift_rejected_o  (drift_rejected_o),
    .clk_o             (clk_o),
    .rise_o            (rise_o),
    .fall_o            (fall_o)
  );

  always #5 clk = ~clk;

  int    cyc      = 0;
  int    last_cyc = 0;
  int    res_cnt  = 0;
  int    rej_cnt  = 0;
  int    errors   = 0;
  int    checks   = 0;
  logic  exp_lvl  = 1'b0;
  edge_t obs_q[$];
  edge_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records each generated edge and counts completion pulses.
  always @(negedge clk) begin
    if (drift_res_o)      res_cnt <= res_cnt + 1;
    if (drift_rejected_o) rej_cnt <= rej_cnt + 1;
    if (!rst_n || clear_state_i) begin
      last_cyc <= cyc;
    end else if (rise_o || fall_o) begin
      obs_q.push_back('{gap: cyc - last_cyc, rise: rise_o, lvl: clk_o,
                        res: drift_res_o, rej: drift_rejected_o});
      last_cyc <= cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_edge(input int gap, input logic res, input logic rej);
    exp_lvl = ~exp_lvl;
    exp_q.push_back('{gap: gap, rise: exp_lvl, lvl: exp_lvl, res: res, rej: rej});
  endtask

  // Pop observed edges as they arrive and compare against the expected queue.
  task automatic drain(input int n, input string tag);
    edge_t e;
    edge_t o;
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      while (obs_q.size() == 0 && guard < 300) begin
        tick();
        guard++;
      end
      if (obs_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s[%0d] timeout: got no edge, expected one", tag, i);
        return;
      end
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.gap !== e.gap) begin
        errors++;
        $display("FAIL %s[%0d] gap: got %0d expected %0d", tag, i, o.gap, e.gap);
      end
      checks++;
      if (o.rise !== e.rise || o.lvl !== e.lvl) begin
        errors++;
        $display("FAIL %s[%0d] polarity: got rise=%b clk=%b expected %b", tag, i, o.rise, o.lvl, e.rise);
      end
      checks++;
      if (o.res !== e.res || o.rej !== e.rej) begin
        errors++;
        $display("FAIL %s[%0d] res/rej: got %b/%b expected %b/%b", tag, i, o.res, o.rej, e.res, e.rej);
      end
    end
  endtask

  task automatic check_counts(input string tag, input int r0, input int j0, input int dr, input int dj);
    checks++;
    if (res_cnt - r0 !== dr || rej_cnt - j0 !== dj) begin
      errors++;
      $display("FAIL %s counts: got res=%0d rej=%0d expected res=%0d rej=%0d",
               tag, res_cnt - r0, rej_cnt - j0, dr, dj);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({clk_o, rise_o, fall_o, drift_res_o, drift_rejected_o} !== 5'b0) begin
      errors++;
      $display("FAIL %s outputs: got clk=%b rise=%b fall=%b res=%b rej=%b expected all 0",
               tag, clk_o, rise_o, fall_o, drift_res_o, drift_rejected_o);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("reset_async");
    tick();
    tick();
    check_idle_outputs("reset_held");
    rst_n   = 1'b1;
    exp_lvl = 1'b0;
    push_edge(1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push_edge(5, 1'b0, 1'b0);
    drain(5, "nominal");
  endtask

  task automatic test_delay();
    int r0 = res_cnt;
    int j0 = rej_cnt;
    drift_direction_i = DRIFT_DELAY;
    drift_req_i       = 1'b1;
    push_edge(5, 1'b1, 1'b0);
    push_edge(6, 1'b0, 1'b0);
    push_edge(5, 1'b0, 1'b0);
    drain(1, "delay");
    drift_req_i = 1'b0;
    drain(2, "delay");
    check_counts("delay", r0, j0, 1, 0);
  endtask

  task automatic test_advance();
    int r0 = res_cnt;
    int j0 = rej_cnt;
    drift_direction_i = DRIFT_ADVANCE;
    drift_req_i       = 1'b1;
    push_edge(5, 1'b1, 1'b0);
    push_edge(4, 1'b0, 1'b0);
    push_edge(5, 1'b0, 1'b0);
    drain(1, "advance");
    drift_req_i = 1'b0;
    drain(2, "advance");
    check_counts("advance", r0, j0, 1, 0);
    // Period 1 is clamped to 2; an advance there must be rejected.
    half_period_i = W'(1);
    push_edge(5, 1'b0, 1'b0);
    push_edge(2, 1'b0, 1'b0);
    push_edge(2, 1'b0, 1'b0);
    drain(3, "clamp");
    r0 = res_cnt;
    j0 = rej_cnt;
    drift_req_i = 1'b1;
    push_edge(2, 1'b1, 1'b1);
    push_edge(2, 1'b0, 1'b0);
    push_edge(2, 1'b0, 1'b0);
    drain(1, "reject");
    drift_req_i = 1'b0;
    drain(2, "reject");
    check_counts("reject", r0, j0, 1, 1);
  endtask

  task automatic test_max_period();
    half_period_i = W'(15);
    push_edge(2, 1'b0, 1'b0);
    drain(1, "max_prep");
    drift_direction_i = DRIFT_DELAY;
    drift_req_i       = 1'b1;
    push_edge(15, 1'b1, 1'b0);
    push_edge(16, 1'b0, 1'b0);
    push_edge(15, 1'b0, 1'b0);
    drain(1, "max_delay");
    drift_req_i = 1'b0;
    drain(2, "max_delay");
  endtask

  task automatic test_back_to_back();
    int r0;
    int j0;
    half_period_i = W'(5);
    push_edge(15, 1'b0, 1'b0);
    drain(1, "hold_prep");
    r0 = res_cnt;
    j0 = rej_cnt;
    drift_direction_i = DRIFT_DELAY;
    drift_req_i       = 1'b1;
    push_edge(5, 1'b1, 1'b0);
    push_edge(6, 1'b0, 1'b0);
    push_edge(5, 1'b0, 1'b0);
    drain(3, "hold");
    for (int i = 0; i < 4; i++) tick();
    check_counts("hold_once", r0, j0, 1, 0);
    drift_req_i = 1'b0;
    push_edge(5, 1'b0, 1'b0);
    drain(1, "hold_drop");
    drift_req_i = 1'b1;
    push_edge(5, 1'b1, 1'b0);
    push_edge(6, 1'b0, 1'b0);
    drain(2, "second");
    drift_req_i = 1'b0;
    push_edge(5, 1'b0, 1'b0);
    drain(1, "second");
    check_counts("hold_twice", r0, j0, 2, 0);
  endtask

  task automatic test_enable();
    logic snap;
    drift_direction_i = DRIFT_DELAY;
    drift_req_i       = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    snap     = clk_o;
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (clk_o !== snap || rise_o !== 1'b0 || fall_o !== 1'b0) begin
        errors++;
        $display("FAIL enable_freeze[%0d]: got clk=%b rise=%b fall=%b expected clk=%b no pulse",
                 i, clk_o, rise_o, fall_o, snap);
      end
    end
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL enable_no_edge: got %0d edges expected 0", obs_q.size());
    end
    enable_i = 1'b1;
    push_edge(8, 1'b1, 1'b0);
    push_edge(6, 1'b0, 1'b0);
    push_edge(5, 1'b0, 1'b0);
    drain(1, "resume");
    drift_req_i = 1'b0;
    drain(2, "resume");
  endtask

  task automatic test_abort();
    int r0 = res_cnt;
    int j0 = rej_cnt;
    drift_direction_i = DRIFT_ADVANCE;
    drift_req_i       = 1'b1;
    tick();
    tick();
    clear_state_i = 1'b1;
    tick();
    check_idle_outputs("clear_next");
    clear_state_i = 1'b0;
    drift_req_i   = 1'b0;
    exp_lvl       = 1'b0;
    push_edge(1, 1'b0, 1'b0);
    push_edge(5, 1'b0, 1'b0);
    push_edge(5, 1'b0, 1'b0);
    drain(3, "after_clear");
    check_counts("clear", r0, j0, 0, 0);
    // Same abort, this time through the asynchronous reset.
    drift_req_i = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1 check_idle_outputs("reset_midop");
    tick();
    rst_n       = 1'b1;
    drift_req_i = 1'b0;
    exp_lvl     = 1'b0;
    push_edge(1, 1'b0, 1'b0);
    push_edge(5, 1'b0, 1'b0);
    push_edge(5, 1'b0, 1'b0);
    drain(3, "after_reset");
    check_counts("reset_abort", r0, j0, 0, 0);
  endtask

  initial begin
    enable_i          = 1'b1;
    clear_state_i     = 1'b0;
    half_period_i     = W'(5);
    drift_req_i       = 1'b0;
    drift_direction_i = DRIFT_DELAY;
    test_reset();
    test_delay();
    test_advance();
    test_max_period();
    test_back_to_back();
    test_enable();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
